// File: rtl/triplet_loader_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : triplet_loader_ctrl_pkg
// Brief  : Shared state encoding and default widths for triplet_loader_ctrl.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package triplet_loader_ctrl_pkg;

  localparam int DEFAULT_W = 2;
  localparam int STATE_W   = 3;

  typedef enum logic [STATE_W-1:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_C  = 3'd2,
    PRESENT = 3'd3,
    RESULT  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/triplet_loader_ctrl_sat_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : sat_counter
// Brief  : Up-counter that sticks at all-ones; synchronous clear wins over
//          increment.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // Count register: clear has priority, increment stops at the maximum value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/triplet_loader_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : triplet_loader_ctrl
// Brief  : Collects three symbols into a/b/c, presents them to the external
//          comparator for one cycle, holds the result for a downstream
//          handshake, and keeps saturating triplet/match statistics.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module triplet_loader_ctrl
  import triplet_loader_ctrl_pkg::*;
#(
  parameter int W     = DEFAULT_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sym_valid,
  input  logic [W-1:0]     sym_data,
  output logic             sym_ready,
  output logic [W-1:0]     a,
  output logic [W-1:0]     b,
  output logic [W-1:0]     c,
  input  logic             cmp_result,
  output logic             out_valid,
  output logic             out_match,
  input  logic             out_ready,
  input  logic             clr,
  output logic [CNT_W-1:0] triplet_count,
  output logic [CNT_W-1:0] match_count
);

  state_t state;
  state_t state_next;
  logic   xfer;
  logic   inc_trip;
  logic   inc_match;

  assign xfer      = sym_valid && sym_ready;
  assign inc_trip  = (state == PRESENT);
  assign inc_match = (state == PRESENT) && cmp_result;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD_A;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake decode; stray encodings fall back to LOAD_A.
  always_comb begin
    state_next = state;
    sym_ready  = 1'b0;
    out_valid  = 1'b0;
    case (state)
      LOAD_A: begin
        sym_ready = 1'b1;
        if (sym_valid) state_next = LOAD_B;
      end
      LOAD_B: begin
        sym_ready = 1'b1;
        if (sym_valid) state_next = LOAD_C;
      end
      LOAD_C: begin
        sym_ready = 1'b1;
        if (sym_valid) state_next = PRESENT;
      end
      PRESENT: begin
        state_next = RESULT;
      end
      RESULT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = LOAD_A;
      end
      default: begin
        state_next = LOAD_A;
      end
    endcase
  end

  // Symbol registers and captured comparator result; each holds until rewritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a         <= '0;
      b         <= '0;
      c         <= '0;
      out_match <= 1'b0;
    end else begin
      if (xfer && (state == LOAD_A)) a <= sym_data;
      if (xfer && (state == LOAD_B)) b <= sym_data;
      if (xfer && (state == LOAD_C)) c <= sym_data;
      if (state == PRESENT) out_match <= cmp_result;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_trip_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_trip),
    .clr   (clr),
    .count (triplet_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_match),
    .clr   (clr),
    .count (match_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_triplet_loader_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_triplet_loader_ctrl
// Brief  : Table-driven bench for triplet_loader_ctrl with the comparator
//          function modelled inline; a second instance with CNT_W=2 shares
//          the stimulus to exercise counter saturation.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_triplet_loader_ctrl;

  logic       clk;
  logic       rst_n;
  logic       sym_valid;
  logic [1:0] sym_data;
  logic       out_ready;
  logic       clr;

  logic       sym_ready, out_valid, out_match, cmp_result;
  logic [1:0] a, b, c;
  logic [7:0] triplet_count, match_count;

  logic       sym_ready2, out_valid2, out_match2, cmp_result2;
  logic [1:0] a2, b2, c2;
  logic [1:0] triplet_count2, match_count2;

  // Comparator stage: ({a,b,c} == {b,c,a}).
  assign cmp_result  = ({a, b, c} == {b, c, a});
  assign cmp_result2 = ({a2, b2, c2} == {b2, c2, a2});

  triplet_loader_ctrl #(.W(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym_data(sym_data),
    .sym_ready(sym_ready), .a(a), .b(b), .c(c), .cmp_result(cmp_result),
    .out_valid(out_valid), .out_match(out_match), .out_ready(out_ready),
    .clr(clr), .triplet_count(triplet_count), .match_count(match_count)
  );

  triplet_loader_ctrl #(.W(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym_data(sym_data),
    .sym_ready(sym_ready2), .a(a2), .b(b2), .c(c2), .cmp_result(cmp_result2),
    .out_valid(out_valid2), .out_match(out_match2), .out_ready(out_ready),
    .clr(clr), .triplet_count(triplet_count2), .match_count(match_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else passed++;
  endtask

  // Drive one symbol (optionally after idle cycles); returns at the negedge
  // following the transfer edge.
  task automatic send_sym(input logic [1:0] d, input int gap);
    if (gap > 0) begin
      sym_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    sym_valid = 1'b1;
    sym_data  = d;
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0] s0, s1, s2;
    int         gap;
    int         rdy;
    logic       m;
    logic [7:0] tc, mc;
    logic [1:0] tc2, mc2;
  } vec_t;

  vec_t vecs[11];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{2'd1, 2'd2, 2'd3, 0, 0, 1'b0, 8'd1, 8'd0, 2'd1, 2'd0};
    vecs[1] = '{2'd3, 2'd0, 2'd1, 0, 0, 1'b0, 8'd2, 8'd0, 2'd2, 2'd0};
    vecs[2] = '{2'd2, 2'd2, 2'd2, 0, 0, 1'b1, 8'd3, 8'd1, 2'd3, 2'd1};
    vecs[3] = '{2'd0, 2'd3, 2'd2, 2, 3, 1'b0, 8'd4, 8'd1, 2'd3, 2'd1};
    vecs[4] = '{2'd3, 2'd3, 2'd3, 2, 3, 1'b1, 8'd5, 8'd2, 2'd3, 2'd2};
    // after mid-triplet reset
    vecs[5] = '{2'd1, 2'd1, 2'd1, 0, 0, 1'b1, 8'd1, 8'd1, 2'd1, 2'd1};
    vecs[6] = '{2'd3, 2'd3, 2'd3, 0, 0, 1'b1, 8'd2, 8'd2, 2'd2, 2'd2};
    vecs[7] = '{2'd3, 2'd3, 2'd3, 0, 0, 1'b1, 8'd3, 8'd3, 2'd3, 2'd3};
    vecs[8] = '{2'd3, 2'd3, 2'd3, 0, 0, 1'b1, 8'd4, 8'd4, 2'd3, 2'd3};
    vecs[9] = '{2'd3, 2'd3, 2'd3, 0, 0, 1'b1, 8'd5, 8'd5, 2'd3, 2'd3};
    vecs[10]= '{2'd3, 2'd3, 2'd3, 0, 0, 1'b1, 8'd6, 8'd6, 2'd3, 2'd3};

    rst_n = 1'b0; sym_valid = 1'b0; sym_data = 2'd0; out_ready = 1'b1; clr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_a", {30'd0, a}, 0);
    check("rst_b", {30'd0, b}, 0);
    check("rst_c", {30'd0, c}, 0);
    check("rst_sym_ready", {31'd0, sym_ready}, 1);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out_match", {31'd0, out_match}, 0);
    check("rst_tcount", {24'd0, triplet_count}, 0);
    check("rst_mcount", {24'd0, match_count}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      if (i == 5) begin
        // Partial triplet 10,10 then asynchronous reset while in LOAD_C.
        send_sym(2'd2, 0);
        send_sym(2'd2, 0);
        sym_valid = 1'b0;
        check("pre_rst_b", {30'd0, b}, 2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_a", {30'd0, a}, 0);
        check("arst_b", {30'd0, b}, 0);
        check("arst_c", {30'd0, c}, 0);
        check("arst_sym_ready", {31'd0, sym_ready}, 1);
        check("arst_out_match", {31'd0, out_match}, 0);
        check("arst_tcount", {24'd0, triplet_count}, 0);
        check("arst_mcount", {24'd0, match_count}, 0);
        check("arst_tcount2", {30'd0, triplet_count2}, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
      end

      send_sym(vecs[i].s0, vecs[i].gap);
      send_sym(vecs[i].s1, vecs[i].gap);
      send_sym(vecs[i].s2, vecs[i].gap);
      sym_valid = 1'b0;
      // PRESENT cycle
      check($sformatf("v%0d_a", i), {30'd0, a}, {30'd0, vecs[i].s0});
      check($sformatf("v%0d_b", i), {30'd0, b}, {30'd0, vecs[i].s1});
      check($sformatf("v%0d_c", i), {30'd0, c}, {30'd0, vecs[i].s2});
      check($sformatf("v%0d_present_ready", i), {31'd0, sym_ready}, 0);
      check($sformatf("v%0d_present_valid", i), {31'd0, out_valid}, 0);
      @(negedge clk);
      // RESULT cycle
      check($sformatf("v%0d_valid", i), {31'd0, out_valid}, 1);
      check($sformatf("v%0d_valid2", i), {31'd0, out_valid2}, 1);
      check($sformatf("v%0d_match", i), {31'd0, out_match}, {31'd0, vecs[i].m});
      check($sformatf("v%0d_match2", i), {31'd0, out_match2}, {31'd0, vecs[i].m});
      check($sformatf("v%0d_tcount", i), {24'd0, triplet_count}, {24'd0, vecs[i].tc});
      check($sformatf("v%0d_mcount", i), {24'd0, match_count}, {24'd0, vecs[i].mc});
      check($sformatf("v%0d_tcount2", i), {30'd0, triplet_count2}, {30'd0, vecs[i].tc2});
      check($sformatf("v%0d_mcount2", i), {30'd0, match_count2}, {30'd0, vecs[i].mc2});
      if (vecs[i].rdy > 0) begin
        out_ready = 1'b0;
        sym_valid = 1'b1;               // must be ignored while sym_ready=0
        sym_data  = vecs[i].s0 ^ 2'b11;
        for (int k = 0; k < vecs[i].rdy; k++) begin
          @(negedge clk);
          check($sformatf("v%0d_bp_valid", i), {31'd0, out_valid}, 1);
          check($sformatf("v%0d_bp_match", i), {31'd0, out_match}, {31'd0, vecs[i].m});
          check($sformatf("v%0d_bp_ready", i), {31'd0, sym_ready}, 0);
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
      sym_valid = 1'b0;
      check($sformatf("v%0d_done_valid", i), {31'd0, out_valid}, 0);
      check($sformatf("v%0d_done_ready", i), {31'd0, sym_ready}, 1);
      check($sformatf("v%0d_hold_match", i), {31'd0, out_match}, {31'd0, vecs[i].m});
      check($sformatf("v%0d_hold_a", i), {30'd0, a}, {30'd0, vecs[i].s0});
      check($sformatf("v%0d_tcount_stable", i), {24'd0, triplet_count}, {24'd0, vecs[i].tc});
    end

    // Clear during the PRESENT cycle of a matching triplet.
    send_sym(2'd0, 0);
    send_sym(2'd0, 0);
    send_sym(2'd0, 0);
    sym_valid = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_valid", {31'd0, out_valid}, 1);
    check("clr_match", {31'd0, out_match}, 1);
    check("clr_tcount", {24'd0, triplet_count}, 0);
    check("clr_mcount", {24'd0, match_count}, 0);
    check("clr_tcount2", {30'd0, triplet_count2}, 0);
    check("clr_mcount2", {30'd0, match_count2}, 0);
    @(negedge clk);
    check("clr_done_valid", {31'd0, out_valid}, 0);
    check("clr_done_match", {31'd0, out_match}, 1);
    check("clr_done_tcount", {24'd0, triplet_count}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
